accumulator_bank_pingpong: RTL and testbench
============================================

// Module: accumulator_bank_pingpong
// PURPOSE
//  Double-buffered accumulator bank, successor to the fixed front/back bank pair. The front bank
//  accumulates sign-extended 2/4/8-bit partial sums per entry with optional saturation. The back
//  bank drains over a valid/ready stream. A swap handshake exchanges the banks only once the back
//  bank is empty. Sits between the multiplier array crossbar and the output/next-layer buffer.
// PARAMETERS
//  BANK_DEPTH              8    entries per bank; any value >= 2, not restricted to powers of 2
//  SMALLEST_ELEMENT_WIDTH  4    base element width; ACC_WIDTH = 4*SMALLEST_ELEMENT_WIDTH (16)
//  IN_WIDTH                8    width of the accumulate data input
//  SATURATE                1    1: clamp sums to the signed ACC_WIDTH range; 0: wrap two's-complement
// PORTS
//  clk             in   1                 clock, all state updates on rising edge
//  reset           in   1                 asynchronous, active-high reset
//  bitwidth        in   2                 0:2-bit, 1:4-bit, 2:8-bit, 3:8-bit (same as 2) operand width
//  acc_valid       in   1                 accumulate request for the front bank
//  acc_entry       in   $clog2(BANK_DEPTH) target entry in the front bank
//  acc_data        in   IN_WIDTH          operand; only the low 2/4/8 bits are used, per bitwidth
//  acc_dropped     out  1                 sticky: an acc_entry >= BANK_DEPTH was seen; cleared by reset
//  swap_req        in   1                 request to exchange the banks
//  swap_ready      out  1                 1 when the back bank is EMPTY, so a swap is accepted
//  out_valid       out  1                 back-bank entry presented on out_data
//  out_ready       in   1                 downstream accepts out_data
//  out_index       out  $clog2(BANK_DEPTH) entry index of out_data
//  out_data        out  ACC_WIDTH         accumulated value, signed
//  out_last        out  1                 out_index == BANK_DEPTH-1 while out_valid
//  out_saturated   out  1                 some sum in the draining bank clamped; valid with out_valid
// BEHAVIOUR
//  - Reset: all entries of both banks 0, bank_sel=0, back state EMPTY, drain pointer 0.
//    Reset output values: out_valid=0, out_index=0, out_last=0, out_saturated=0, swap_ready=1,
//    acc_dropped=0. Reset asserted mid-drain or mid-accumulate aborts the operation; no partial
//    data is retained.
//  - Sign extension: the operand acc_data[w-1:0] is sign-extended to ACC_WIDTH, with w = 2, 4 or 8
//    per bitwidth. bitwidth is sampled in the same cycle as acc_valid.
//  - Accumulate: when acc_valid and acc_entry < BANK_DEPTH, then front[acc_entry] <= front + sext
//    at the next edge. Every cycle is a full read-modify-write, so back-to-back hits on the same
//    entry chain with no stall and no lost update. If acc_entry >= BANK_DEPTH, the write is
//    ignored and acc_dropped is set.
//  - Saturation (SATURATE=1): the sum is computed at ACC_WIDTH+1 bits. It clamps to
//    +(2^(ACC_WIDTH-1)-1) and -2^(ACC_WIDTH-1). A clamp sets the front bank's sat flag.
//    With SATURATE=0 the sum wraps and the flag never sets.
//  - Back-bank FSM: EMPTY -> DRAIN when a swap is accepted. It stays in DRAIN while entries remain,
//    and returns DRAIN -> EMPTY on the handshake where out_last is 1.
//  - Swap accept condition: swap_req && swap_ready. At that edge, bank_sel toggles. The old front
//    bank, including any acc_valid write from that same cycle, becomes the back bank, and its sat
//    flag moves to out_saturated. The new front bank is zeroed and its sat flag cleared. The drain
//    pointer is set to 0.
//  - swap_req while in DRAIN: not accepted and has no effect; the requester holds swap_req.
//    Accumulation continues on the front bank meanwhile.
//  - Drain: out_valid is 1 in DRAIN. out_data = back[ptr] and out_index = ptr, both from registers.
//    out_data and out_index are stable while out_valid && !out_ready. On out_valid && out_ready,
//    ptr increments; after the last entry the FSM goes to EMPTY.
//  - Swap latency: first out_valid appears in the cycle after the swap is accepted.
//    The minimum swap-to-swap interval is BANK_DEPTH+1 cycles.
//  - Simultaneous final drain handshake and swap_req: not accepted in that cycle, since swap_ready
//    is still 0. The swap is accepted on the next cycle, with no bubble beyond that one cycle.
// TESTING
//  1 reset, bitwidth=0, acc_data=8'h03 on entry 2 three times, then swap -> out_index 2 gives
//    16'hFFFD; all other entries give 0; out_saturated=0.
//  2 bitwidth=1: 8'h0F then 8'h07 on entry 0. bitwidth=2: 8'h80 on entry 1. Swap -> entry0=16'h0006,
//    entry1=16'hFF80.
//  3 SATURATE=1, bitwidth=2, 8'h7F into entry 5 for 300 cycles -> 16'h7FFF and out_saturated=1.
//    SATURATE=0 -> 16'h94D4 (wrapped) and out_saturated=0.
//  4 Swap, then toggle out_ready randomly -> indices 0..7 in order, no duplicates; out_last only on
//    7; swap_ready=0 until the cycle after index 7 is accepted.
//  5 swap_req held during drain while entry 3 is accumulated with +1 each cycle -> swap accepted
//    exactly one cycle after the last handshake. The new back bank holds every +1, including one
//    issued in the accept cycle.
//  6 acc_entry=BANK_DEPTH (BANK_DEPTH=6) -> acc_dropped=1, no entry changes.
//    Assert reset mid-drain -> out_valid=0 and swap_ready=1 immediately (async), all entries 0.

Source files
------------

// File: rtl/accumulator_bank_pingpong.sv
// Double-buffered accumulator bank. The front bank takes sign-extended 2/4/8-bit partial sums
// with optional saturation. The back bank drains over valid/ready, and the banks swap only when the back bank is empty.
module accumulator_bank_pingpong #(
  parameter int BANK_DEPTH             = 8,
  parameter int SMALLEST_ELEMENT_WIDTH = 4,
  parameter int IN_WIDTH               = 8,
  parameter bit SATURATE               = 1'b1,
  localparam int ACC_WIDTH             = 4 * SMALLEST_ELEMENT_WIDTH,
  localparam int IDX_W                 = $clog2(BANK_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           bitwidth,
  input  logic                 acc_valid,
  input  logic [IDX_W-1:0]     acc_entry,
  input  logic [IN_WIDTH-1:0]  acc_data,
  output logic                 acc_dropped,
  input  logic                 swap_req,
  output logic                 swap_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_index,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 out_saturated,
  output logic                 dbg_back_state
);

  // Stream handshake: a back-bank entry transfers on any rising edge where out_valid && out_ready;
  // out_data/out_index hold steady while out_valid && !out_ready. A swap transfers on swap_req && swap_ready.

  typedef enum logic {BACK_EMPTY = 1'b0, BACK_DRAIN = 1'b1} back_state_e;

  localparam logic [IDX_W:0]   DEPTH_W = (IDX_W + 1)'(BANK_DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(BANK_DEPTH - 1);

  back_state_e            state_q, state_d;
  logic [ACC_WIDTH-1:0]   bank_q [2][BANK_DEPTH];
  logic [ACC_WIDTH-1:0]   bank_d [2][BANK_DEPTH];
  logic [1:0]             sat_q, sat_d;
  logic                   bank_sel_q, bank_sel_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   out_sat_q, out_sat_d;
  logic                   dropped_q, dropped_d;

  logic [ACC_WIDTH-1:0]   sext;
  logic [ACC_WIDTH-1:0]   acc_cur;
  logic [ACC_WIDTH:0]     sum_wide;
  logic [ACC_WIDTH-1:0]   acc_new;
  logic                   ovf;
  logic                   in_range;
  logic                   swap_acc;

  always_comb begin
    case (bitwidth)
      2'd0:    sext = {{(ACC_WIDTH-2){acc_data[1]}}, acc_data[1:0]};
      2'd1:    sext = {{(ACC_WIDTH-4){acc_data[3]}}, acc_data[3:0]};
      default: sext = {{(ACC_WIDTH-8){acc_data[7]}}, acc_data[7:0]};
    endcase
  end

  // One extra bit of headroom exposes signed overflow as a mismatch of the top two bits.
  always_comb begin
    in_range = ({1'b0, acc_entry} < DEPTH_W);
    acc_cur  = bank_q[bank_sel_q][acc_entry];
    sum_wide = {acc_cur[ACC_WIDTH-1], acc_cur} + {sext[ACC_WIDTH-1], sext};
    ovf      = SATURATE && (sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1]);
    if (ovf) begin
      acc_new = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      acc_new = sum_wide[ACC_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    sat_d      = sat_q;
    bank_sel_d = bank_sel_q;
    ptr_d      = ptr_q;
    out_sat_d  = out_sat_q;
    dropped_d  = dropped_q;
    swap_acc   = swap_req && (state_q == BACK_EMPTY);

    if (acc_valid) begin
      if (in_range) begin
        bank_d[bank_sel_q][acc_entry] = acc_new;
        sat_d[bank_sel_q]             = sat_q[bank_sel_q] | ovf;
      end else begin
        dropped_d = 1'b1;
      end
    end

    // The accept-cycle write above is already in bank_d, so it travels with the old front.
    if (swap_acc) begin
      bank_sel_d = ~bank_sel_q;
      out_sat_d  = sat_d[bank_sel_q];
      sat_d[~bank_sel_q] = 1'b0;
      for (int i = 0; i < BANK_DEPTH; i++) begin
        bank_d[~bank_sel_q][i] = '0;
      end
      ptr_d   = '0;
      state_d = BACK_DRAIN;
    end

    if (state_q == BACK_DRAIN && out_ready) begin
      if (ptr_q == LAST) begin
        ptr_d   = '0;
        state_d = BACK_EMPTY;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BACK_EMPTY;
      bank_q     <= '{default: '0};
      sat_q      <= '0;
      bank_sel_q <= 1'b0;
      ptr_q      <= '0;
      out_sat_q  <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      sat_q      <= sat_d;
      bank_sel_q <= bank_sel_d;
      ptr_q      <= ptr_d;
      out_sat_q  <= out_sat_d;
      dropped_q  <= dropped_d;
    end
  end

  assign swap_ready     = (state_q == BACK_EMPTY);
  assign out_valid      = (state_q == BACK_DRAIN);
  assign out_index      = ptr_q;
  assign out_data       = bank_q[~bank_sel_q][ptr_q];
  assign out_last       = out_valid && (ptr_q == LAST);
  assign out_saturated  = out_valid && out_sat_q;
  assign acc_dropped    = dropped_q;
  assign dbg_back_state = (state_q == BACK_DRAIN);

endmodule

// File: tb/tb_accumulator_bank_pingpong.sv
// Directed bench for accumulator_bank_pingpong: a saturating depth-8 instance, a wrapping twin,
// and a depth-6 instance share stimulus. Expected drain values come from exp_q.
module tb_accumulator_bank_pingpong;

  logic        clk;
  logic        reset;
  logic [1:0]  bitwidth;
  logic        acc_valid;
  logic [2:0]  acc_entry;
  logic [7:0]  acc_data;
  logic        swap_req;
  logic        out_ready;

  logic        a_dropped, a_swap_ready, a_out_valid, a_out_last, a_out_sat, a_dbg;
  logic [2:0]  a_out_index;
  logic [15:0] a_out_data;
  logic        w_dropped, w_swap_ready, w_out_valid, w_out_last, w_out_sat, w_dbg;
  logic [2:0]  w_out_index;
  logic [15:0] w_out_data;
  logic        s_dropped, s_swap_ready, s_out_valid, s_out_last, s_out_sat, s_dbg;
  logic [2:0]  s_out_index;
  logic [15:0] s_out_data;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  accumulator_bank_pingpong dut (
    .clk(clk), .reset(reset), .bitwidth(bitwidth), .acc_valid(acc_valid), .acc_entry(acc_entry),
    .acc_data(acc_data), .acc_dropped(a_dropped), .swap_req(swap_req), .swap_ready(a_swap_ready),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_index(a_out_index), .out_data(a_out_data),
    .out_last(a_out_last), .out_saturated(a_out_sat), .dbg_back_state(a_dbg));

  accumulator_bank_pingpong #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .bitwidth(bitwidth), .acc_valid(acc_valid), .acc_entry(acc_entry),
    .acc_data(acc_data), .acc_dropped(w_dropped), .swap_req(swap_req), .swap_ready(w_swap_ready),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_index(w_out_index), .out_data(w_out_data),
    .out_last(w_out_last), .out_saturated(w_out_sat), .dbg_back_state(w_dbg));

  accumulator_bank_pingpong #(.BANK_DEPTH(6)) dut6 (
    .clk(clk), .reset(reset), .bitwidth(bitwidth), .acc_valid(acc_valid), .acc_entry(acc_entry),
    .acc_data(acc_data), .acc_dropped(s_dropped), .swap_req(swap_req), .swap_ready(s_swap_ready),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_index(s_out_index), .out_data(s_out_data),
    .out_last(s_out_last), .out_saturated(s_out_sat), .dbg_back_state(s_dbg));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic acc_one(input logic [1:0] bw, input logic [2:0] entry, input logic [7:0] data);
    acc_valid = 1'b1;
    bitwidth  = bw;
    acc_entry = entry;
    acc_data  = data;
    step();
    acc_valid = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic push_exp(input int depth, input int hot, input logic [15:0] hot_val);
    exp_q.delete();
    for (int i = 0; i < depth; i++) exp_q.push_back(i == hot ? hot_val : 16'h0000);
  endtask

  // which: 0 = saturating depth-8 instance, 1 = depth-6 instance
  task automatic drain_check(input int which, input logic sat_exp, input string tag);
    int          depth;
    logic        v, l, s, r;
    logic [2:0]  idx;
    logic [15:0] d, e;
    depth     = (which == 0) ? 8 : 6;
    out_ready = 1'b1;
    for (int i = 0; i < depth; i++) begin
      if (which == 0) begin
        v = a_out_valid; idx = a_out_index; d = a_out_data; l = a_out_last; s = a_out_sat;
      end else begin
        v = s_out_valid; idx = s_out_index; d = s_out_data; l = s_out_last; s = s_out_sat;
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk({tag, "_valid"}, 32'(v), 32'(1'b1));
      chk({tag, "_index"}, 32'(idx), 32'(i));
      chk({tag, "_data"}, 32'(d), 32'(e));
      chk({tag, "_last"}, 32'(l), 32'(i == depth - 1));
      chk({tag, "_sat"}, 32'(s), 32'(sat_exp));
      step();
    end
    out_ready = 1'b0;
    r = (which == 0) ? a_swap_ready : s_swap_ready;
    chk({tag, "_swap_ready_after"}, 32'(r), 32'(1'b1));
  endtask

  initial begin : stim
    int count;
    int cycles;
    bitwidth  = 2'd0;
    acc_valid = 1'b0;
    acc_entry = '0;
    acc_data  = '0;
    swap_req  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_out_index", 32'(a_out_index), 0);
    chk("rst_out_last", 32'(a_out_last), 0);
    chk("rst_out_sat", 32'(a_out_sat), 0);
    chk("rst_swap_ready", 32'(a_swap_ready), 1);
    chk("rst_dropped", 32'(a_dropped), 0);
    reset = 1'b0;
    step();

    // 1: 2-bit operand 2'b11 = -1, three times into entry 2
    acc_valid = 1'b1; bitwidth = 2'd0; acc_entry = 3'd2; acc_data = 8'h03;
    repeat (3) step();
    acc_valid = 1'b0;
    do_swap();
    push_exp(8, 2, 16'hFFFD);
    drain_check(0, 1'b0, "t1");

    // 2: 4-bit -1 then +7 on entry 0, 8-bit -128 on entry 1
    acc_one(2'd1, 3'd0, 8'h0F);
    acc_one(2'd1, 3'd0, 8'h07);
    acc_one(2'd2, 3'd1, 8'h80);
    do_swap();
    exp_q.delete();
    exp_q.push_back(16'h0006);
    exp_q.push_back(16'hFF80);
    for (int i = 2; i < 8; i++) exp_q.push_back(16'h0000);
    drain_check(0, 1'b0, "t2");

    // 3: 300 x +127 into entry 5; saturating vs wrapping (38100 = 16'h94D4)
    acc_valid = 1'b1; bitwidth = 2'd2; acc_entry = 3'd5; acc_data = 8'h7F;
    repeat (300) step();
    acc_valid = 1'b0;
    do_swap();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_sat_data", 32'(a_out_data), (i == 5) ? 32'h7FFF : 32'h0);
      chk("t3_wrap_data", 32'(w_out_data), (i == 5) ? 32'h94D4 : 32'h0);
      chk("t3_sat_flag", 32'(a_out_sat), 1);
      chk("t3_wrap_flag", 32'(w_out_sat), 0);
      step();
    end
    out_ready = 1'b0;

    // 4: entry i holds i+1; drain under random backpressure
    for (int i = 0; i < 8; i++) acc_one(2'd2, 3'(i), 8'(i + 1));
    do_swap();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(i + 1));
    count  = 0;
    cycles = 0;
    while (count < 8 && cycles < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("t4_valid", 32'(a_out_valid), 1);
      chk("t4_swap_ready_busy", 32'(a_swap_ready), 0);
      chk("t4_index", 32'(a_out_index), 32'(count));
      chk("t4_last", 32'(a_out_last), 32'(count == 7));
      if (out_ready) begin
        chk("t4_data", 32'(a_out_data), 32'(exp_q.pop_front()));
        count++;
      end
      step();
      cycles++;
    end
    out_ready = 1'b0;
    chk("t4_complete", 32'(count), 8);
    chk("t4_swap_ready_after", 32'(a_swap_ready), 1);

    // 5: swap_req held during a drain while entry 3 takes +1 every cycle
    do_swap();
    swap_req = 1'b1; out_ready = 1'b1;
    acc_valid = 1'b1; bitwidth = 2'd2; acc_entry = 3'd3; acc_data = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t5_swap_ready", 32'(a_swap_ready), 32'(k == 8));
      chk("t5_valid", 32'(a_out_valid), 32'(k != 8));
    end
    step();
    swap_req = 1'b0; acc_valid = 1'b0; out_ready = 1'b0;
    chk("t5_accepted", 32'(a_out_valid), 1);
    push_exp(8, 3, 16'h0009);
    drain_check(0, 1'b0, "t5");

    // 6: out-of-range entry on the depth-6 instance, then reset mid-drain
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    acc_one(2'd2, 3'd6, 8'h05);
    chk("t6_dropped6", 32'(s_dropped), 1);
    chk("t6_dropped8", 32'(a_dropped), 0);
    do_swap();
    push_exp(6, -1, 16'h0000);
    drain_check(1, 1'b0, "t6_d6");
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;
    acc_one(2'd2, 3'd1, 8'h05);
    do_swap();
    out_ready = 1'b1;
    acc_valid = 1'b1; acc_entry = 3'd2; acc_data = 8'h03;
    repeat (2) step();
    chk("t6_mid_drain", 32'(a_out_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(a_out_valid), 0);
    chk("t6_async_swap_ready", 32'(a_swap_ready), 1);
    chk("t6_async_index", 32'(a_out_index), 0);
    chk("t6_async_dropped6", 32'(s_dropped), 0);
    acc_valid = 1'b0; out_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    do_swap();
    push_exp(8, -1, 16'h0000);
    drain_check(0, 1'b0, "t6_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
